// File: rtl/sram_mem_controller.sv
// Memory-stage adapter: splits a 32-bit load/store into two 16-bit SRAM phases
// with programmable wait states, holding ready low while the access runs.
module sram_mem_controller #(
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in,
  output logic        sram_we_n
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  localparam logic [31:0] BASE   = 32'(BASE_ADDR);
  localparam logic [3:0]  RELOAD = 4'(WAIT_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [16:0] idx_q, idx_d;
  logic [31:0] wdata_q, wdata_d;
  logic        isWrite_q, isWrite_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] offset;
  logic        unusedBits;

  // Byte-address to word-index mapping; alignment and high bits are dropped.
  assign offset     = address - BASE;
  assign unusedBits = ^{offset[31:19], offset[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      wdata_q   <= '0;
      isWrite_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      isWrite_q <= isWrite_d;
      rdata_q   <= rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    isWrite_d = isWrite_q;
    rdata_d   = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          idx_d     = offset[18:2];
          wdata_d   = write_data;
          isWrite_d = mem_write;
          cnt_d     = RELOAD;
          state_d   = LO;
        end
      end
      LO: begin
        if (cnt_q == 4'd0) begin
          state_d = HI;
          cnt_d   = RELOAD;
          if (!isWrite_q) rdata_d[15:0] = sram_dq_in;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HI: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          if (!isWrite_q) rdata_d[31:16] = sram_dq_in;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // SRAM pins depend only on registered state so they are glitch-free.
  always_comb begin
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_we_n   = 1'b1;
    sram_dq_oe  = 1'b0;
    if (state_q == LO || state_q == HI) begin
      sram_addr   = {idx_q, (state_q == HI)};
      sram_dq_out = (state_q == HI) ? wdata_q[31:16] : wdata_q[15:0];
      sram_we_n   = ~isWrite_q;
      sram_dq_oe  = isWrite_q;
    end
  end

  assign ready     = ((state_q == IDLE) && !mem_read && !mem_write) || (state_q == DONE);
  assign read_data = rdata_q;

endmodule

// File: tb/tb_sram_mem_controller.sv
// Self-checking bench: two controllers (W=1, W=0) against behavioural SRAM
// models and a word-level reference memory.
module tb_sram_mem_controller;

  localparam int BASE = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        memRead   [2];
  logic        memWrite  [2];
  logic [31:0] address   [2];
  logic [31:0] writeData [2];
  logic [31:0] readData  [2];
  logic        ready     [2];
  logic [17:0] sramAddr  [2];
  logic [15:0] sramDqOut [2];
  logic [15:0] sramDqIn  [2];
  logic        sramDqOe  [2];
  logic        sramWeN   [2];

  logic [15:0] sramMem [2][256];
  logic [31:0] refMem  [2][128];
  logic [31:0] lastRead [2];
  int          wOf [2];
  int          checks;
  int          failures;

  sram_mem_controller #(.BASE_ADDR(BASE), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst(rst), .mem_read(memRead[0]), .mem_write(memWrite[0]),
    .address(address[0]), .write_data(writeData[0]), .read_data(readData[0]),
    .ready(ready[0]), .sram_addr(sramAddr[0]), .sram_dq_out(sramDqOut[0]),
    .sram_dq_oe(sramDqOe[0]), .sram_dq_in(sramDqIn[0]), .sram_we_n(sramWeN[0])
  );

  sram_mem_controller #(.BASE_ADDR(BASE), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst), .mem_read(memRead[1]), .mem_write(memWrite[1]),
    .address(address[1]), .write_data(writeData[1]), .read_data(readData[1]),
    .ready(ready[1]), .sram_addr(sramAddr[1]), .sram_dq_out(sramDqOut[1]),
    .sram_dq_oe(sramDqOe[1]), .sram_dq_in(sramDqIn[1]), .sram_we_n(sramWeN[1])
  );

  // Asynchronous-read, clocked-write SRAM models, one per controller.
  assign sramDqIn[0] = sramMem[0][sramAddr[0][7:0]];
  assign sramDqIn[1] = sramMem[1][sramAddr[1][7:0]];

  always @(posedge clk) begin
    if (!sramWeN[0]) sramMem[0][sramAddr[0][7:0]] = sramDqOut[0];
    if (!sramWeN[1]) sramMem[1][sramAddr[1][7:0]] = sramDqOut[1];
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
    end
  endtask

  // One complete access: cycle 0 is the request in IDLE; each phase then lasts
  // W+1 cycles and DONE follows, after which the bench drops the request.
  task automatic applyStimulus(input int d, input logic rd, input logic wr,
                               input logic [31:0] addr, input logic [31:0] data,
                               input logic changeMid);
    logic [31:0] off;
    logic [16:0] idx;
    logic        hiPhase;
    int          w;
    w   = wOf[d];
    off = addr - 32'(BASE);
    idx = off[18:2];
    @(negedge clk);
    memRead[d]   = rd;
    memWrite[d]  = wr;
    address[d]   = addr;
    writeData[d] = data;
    #1 checkOutput("ready_req", 32'(ready[d]), 32'd0);
    for (int c = 1; c <= 2 * w + 3; c++) begin
      @(posedge clk);
      #1;
      if (c == 2 * w + 3) begin
        checkOutput("ready_done", 32'(ready[d]), 32'd1);
        checkOutput("we_n_done", 32'(sramWeN[d]), 32'd1);
        checkOutput("addr_done", 32'(sramAddr[d]), 32'd0);
      end else begin
        hiPhase = (c > w + 1);
        checkOutput("ready_busy", 32'(ready[d]), 32'd0);
        checkOutput("sram_addr", 32'(sramAddr[d]), 32'({idx, hiPhase}));
        checkOutput("dq_out", 32'(sramDqOut[d]), hiPhase ? 32'(data[31:16]) : 32'(data[15:0]));
        checkOutput("we_n", 32'(sramWeN[d]), wr ? 32'd0 : 32'd1);
        checkOutput("dq_oe", 32'(sramDqOe[d]), wr ? 32'd1 : 32'd0);
      end
      if (c == 1 && changeMid) begin
        address[d]   = $urandom;
        writeData[d] = $urandom;
      end
    end
    if (wr) refMem[d][idx[6:0]] = data;
    else    lastRead[d] = refMem[d][idx[6:0]];
    checkOutput("read_data", readData[d], lastRead[d]);
    memRead[d]  = 1'b0;
    memWrite[d] = 1'b0;
    @(posedge clk);
  endtask

  initial begin
    logic [31:0] off;
    int          d;
    int          kind;
    checks   = 0;
    failures = 0;
    wOf[0] = 1;
    wOf[1] = 0;
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      memRead[k] = 1'b0; memWrite[k] = 1'b0; address[k] = '0; writeData[k] = '0;
      lastRead[k] = '0;
      for (int i = 0; i < 256; i++) sramMem[k][i] = 16'($urandom);
    end
    sramMem[0][2] = 16'h5678;
    sramMem[0][3] = 16'h1234;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 128; i++)
        refMem[k][i] = {sramMem[k][2 * i + 1], sramMem[k][2 * i]};

    #12;
    for (int k = 0; k < 2; k++) begin
      checkOutput("rst_ready", 32'(ready[k]), 32'd1);
      checkOutput("rst_we_n", 32'(sramWeN[k]), 32'd1);
      checkOutput("rst_oe", 32'(sramDqOe[k]), 32'd0);
      checkOutput("rst_addr", 32'(sramAddr[k]), 32'd0);
      checkOutput("rst_rdata", readData[k], 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);

    applyStimulus(0, 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 1'b0);
    applyStimulus(0, 1'b1, 1'b0, 32'd1028, 32'h0, 1'b0);
    checkOutput("load_1028", readData[0], 32'h12345678);
    applyStimulus(0, 1'b1, 1'b0, 32'd1024, 32'h0, 1'b0);
    checkOutput("load_1024", readData[0], 32'hDEADBEEF);

    applyStimulus(1, 1'b0, 1'b1, 32'd1032, 32'hA5A50F0F, 1'b0);
    applyStimulus(1, 1'b1, 1'b0, 32'd1032, 32'h0, 1'b0);
    checkOutput("w0_load_1032", readData[1], 32'hA5A50F0F);

    applyStimulus(0, 1'b1, 1'b0, 32'd1028, 32'h0, 1'b0);
    applyStimulus(0, 1'b1, 1'b1, 32'd1036, 32'hCAFEF00D, 1'b0);
    checkOutput("both_keeps_rdata", readData[0], 32'h12345678);
    applyStimulus(0, 1'b1, 1'b0, 32'd1036, 32'h0, 1'b0);
    checkOutput("load_1036", readData[0], 32'hCAFEF00D);

    applyStimulus(0, 1'b0, 1'b1, 32'd1040, 32'h13572468, 1'b1);
    applyStimulus(0, 1'b1, 1'b0, 32'd1040, 32'h0, 1'b0);
    checkOutput("mid_change_load", readData[0], 32'h13572468);

    // Reset in the middle of a write's high phase.
    @(negedge clk);
    memWrite[0]  = 1'b1;
    address[0]   = 32'd1044;
    writeData[0] = 32'h0BADBEEF;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("abort_pre_we_n", 32'(sramWeN[0]), 32'd0);
    checkOutput("abort_pre_addr", 32'(sramAddr[0]), 32'd11);
    #2 rst = 1'b0;
    #1;
    checkOutput("abort_we_n", 32'(sramWeN[0]), 32'd1);
    checkOutput("abort_oe", 32'(sramDqOe[0]), 32'd0);
    checkOutput("abort_addr", 32'(sramAddr[0]), 32'd0);
    checkOutput("abort_rdata0", readData[0], 32'd0);
    checkOutput("abort_rdata1", readData[1], 32'd0);
    checkOutput("abort_ready_req", 32'(ready[0]), 32'd0);
    memWrite[0] = 1'b0;
    #1 checkOutput("abort_ready_idle", 32'(ready[0]), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    lastRead[0] = '0;
    lastRead[1] = '0;
    @(posedge clk);
    #1;
    checkOutput("post_rst_ready", 32'(ready[0]), 32'd1);
    checkOutput("post_rst_we_n", 32'(sramWeN[0]), 32'd1);
    applyStimulus(0, 1'b0, 1'b1, 32'd1044, 32'h600DF00D, 1'b0);
    applyStimulus(0, 1'b1, 1'b0, 32'd1044, 32'h0, 1'b0);
    checkOutput("rewrite_1044", readData[0], 32'h600DF00D);

    // Random accesses over both controllers, including ignored address bits.
    for (int n = 0; n < 60; n++) begin
      d    = int'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 3));
      off  = ($urandom & 32'hFFF8_0000) | (32'($urandom_range(0, 127)) << 2) | ($urandom & 32'h3);
      applyStimulus(d, kind != 1, kind != 0, off + 32'(BASE), $urandom, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
